feedback_seq_gen: RTL and testbench

// - Parametrised, clocked successor to the gate-level feedback circuit: a WIDTH-bit registered

---
 rtl/feedback_seq_gen.sv | 113 +++++++++++
 tb/tb_feedback_seq_gen.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/feedback_seq_gen.sv
// feedback_seq_gen: WIDTH-bit registered feedback sequence generator.
// mode 0 steps a Fibonacci LFSR (feedback = XOR of TAPS-selected bits),
// mode 1 steps a Johnson (twisted-ring) counter. Load has priority over en;
// an all-zero load in LFSR mode is replaced by SEED and flagged on lock_err.
// Optional feature macro: PERIOD_CNT_EN (adds the CNT_W-bit period counter;
// when undefined, period is tied to 0).
module feedback_seq_gen #(
   parameter int unsigned           WIDTH = 8,
   parameter logic [WIDTH-1:0]      TAPS  = 8'hB8,
   parameter logic [WIDTH-1:0]      SEED  = 8'h01,
   parameter int unsigned           CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   output logic [WIDTH-1:0] state,
   output logic             y,
   output logic             wrap,
   output logic             lock_err,
   output logic [CNT_W-1:0] period
);

   // A zero seed would lock the LFSR, so it is promoted to 1.
   localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;

   logic [WIDTH-1:0] state_q, state_d;
   logic             wrap_q, wrap_d;
   logic             lock_err_q, lock_err_d;
   logic [WIDTH-1:0] step_v;

   // Next-state selection: load > en > hold; pulses default low.
   always_comb begin
      state_d    = state_q;
      wrap_d     = 1'b0;
      lock_err_d = 1'b0;
      if (mode) begin
         step_v = {state_q[WIDTH-2:0], ~state_q[WIDTH-1]};
      end else begin
         step_v = {state_q[WIDTH-2:0], ^(state_q & TAPS)};
      end
      if (load) begin
         if (!mode && (load_data == '0)) begin
            state_d    = SEED_EFF;
            lock_err_d = 1'b1;
         end else begin
            state_d = load_data;
         end
      end else if (en) begin
         state_d = step_v;
         wrap_d  = (step_v == SEED_EFF);
      end
   end

   // State and pulse registers, async reset to the seed.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= SEED_EFF;
         wrap_q     <= 1'b0;
         lock_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wrap_q     <= wrap_d;
         lock_err_q <= lock_err_d;
      end
   end

   assign state    = state_q;
   assign y        = state_q[WIDTH-1];
   assign wrap     = wrap_q;
   assign lock_err = lock_err_q;

`ifdef PERIOD_CNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic [CNT_W-1:0] cnt_inc;

   // Step counter: saturating increment; captured into period on a wrap step.
   always_comb begin
      cnt_d    = cnt_q;
      period_d = period_q;
      cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
      if (load) begin
         cnt_d = '0;
      end else if (en) begin
         if (wrap_d) begin
            period_d = cnt_inc;
            cnt_d    = '0;
         end else begin
            cnt_d = cnt_inc;
         end
      end
   end

   // Counter and period registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q    <= '0;
         period_q <= '0;
      end else begin
         cnt_q    <= cnt_d;
         period_q <= period_d;
      end
   end

   assign period = period_q;
`else
   assign period = '0;
`endif

endmodule

// File: tb/tb_feedback_seq_gen.sv
// Directed self-checking bench for feedback_seq_gen (W=4, TAPS=4'hC, SEED=1).
module tb_feedback_seq_gen;

   logic        clk = 1'b0;
   logic        reset;
   logic        en;
   logic        mode;
   logic        load;
   logic [3:0]  load_data;
   logic [3:0]  state;
   logic        y;
   logic        wrap;
   logic        lock_err;
   logic [15:0] period;

   int errors = 0;
   int checks = 0;

   logic [3:0] lfsr_exp [15] = '{4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5,
                                 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};
   logic [3:0] john_exp [8]  = '{4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0, 4'h1};

`ifdef PERIOD_CNT_EN
   localparam logic [15:0] LFSR_PERIOD = 16'd15;
   localparam logic [15:0] JOHN_PERIOD = 16'd8;
`else
   localparam logic [15:0] LFSR_PERIOD = 16'd0;
   localparam logic [15:0] JOHN_PERIOD = 16'd0;
`endif

   feedback_seq_gen #(
      .WIDTH (4),
      .TAPS  (4'hC),
      .SEED  (4'h1),
      .CNT_W (16)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .mode      (mode),
      .load      (load),
      .load_data (load_data),
      .state     (state),
      .y         (y),
      .wrap      (wrap),
      .lock_err  (lock_err),
      .period    (period)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #3;
      reset = 1'b0;
      tick();
   endtask

   initial begin
      reset = 1'b1; en = 1'b0; mode = 1'b0; load = 1'b0; load_data = '0;
      #12;
      // Reset values
      check("rst_state", 32'(state), 32'h1);
      check("rst_y", 32'(y), 32'h0);
      check("rst_wrap", 32'(wrap), 32'h0);
      check("rst_lock", 32'(lock_err), 32'h0);
      check("rst_period", 32'(period), 32'h0);
      reset = 1'b0;
      tick();

      // LFSR full sequence
      en = 1'b1; mode = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick();
         check("lfsr_state", 32'(state), 32'(lfsr_exp[i]));
         check("lfsr_y", 32'(y), 32'(lfsr_exp[i][3]));
         check("lfsr_wrap", 32'(wrap), (i == 14) ? 32'h1 : 32'h0);
      end
      en = 1'b0;
      tick();
      check("lfsr_period", 32'(period), 32'(LFSR_PERIOD));
      check("hold_wrap_low", 32'(wrap), 32'h0);
      check("hold_state", 32'(state), 32'h1);

      // Johnson full sequence
      do_reset();
      en = 1'b1; mode = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         check("john_state", 32'(state), 32'(john_exp[i]));
         check("john_wrap", 32'(wrap), (i == 7) ? 32'h1 : 32'h0);
      end
      en = 1'b0;
      tick();
      check("john_period", 32'(period), 32'(JOHN_PERIOD));

      // Zero load in LFSR mode: guarded to SEED, lock_err one cycle, no wrap
      mode = 1'b0; en = 1'b1;
      tick();                       // state 3 -> 6? no: Johnson left state 1, LFSR step -> 2
      check("pre_zero_state", 32'(state), 32'h2);
      en = 1'b0; load = 1'b1; load_data = 4'h0;
      tick();
      load = 1'b0;
      check("zero_state", 32'(state), 32'h1);
      check("zero_lock", 32'(lock_err), 32'h1);
      check("zero_wrap", 32'(wrap), 32'h0);
      tick();
      check("zero_lock_clr", 32'(lock_err), 32'h0);
      check("zero_state_hold", 32'(state), 32'h1);

      // Load wins over en
      load = 1'b1; en = 1'b1; load_data = 4'h6;
      tick();
      load = 1'b0; en = 1'b0;
      check("load_pri_state", 32'(state), 32'h6);
      check("load_pri_wrap", 32'(wrap), 32'h0);
      check("load_pri_lock", 32'(lock_err), 32'h0);

      // Johnson mode accepts all-zero load
      mode = 1'b1; load = 1'b1; load_data = 4'h0;
      tick();
      load = 1'b0;
      check("john_zero_state", 32'(state), 32'h0);
      check("john_zero_lock", 32'(lock_err), 32'h0);

      // Async reset mid-sequence, between edges
      mode = 1'b0; load = 1'b1; load_data = 4'hB;
      tick();
      load = 1'b0; en = 1'b1;
      tick();
      check("pre_rst_state", 32'(state), 32'h7);
      #2;
      reset = 1'b1;
      #1;
      check("arst_state", 32'(state), 32'h1);
      check("arst_wrap", 32'(wrap), 32'h0);
      check("arst_period", 32'(period), 32'h0);
      en = 1'b0;
      #1;
      reset = 1'b0;
      tick();

      // en toggled every cycle: half-rate sequence
      mode = 1'b0;
      for (int i = 0; i < 30; i++) begin
         en = (i % 2 == 0);
         tick();
         check("tog_state", 32'(state), 32'(lfsr_exp[i / 2]));
         check("tog_wrap", 32'(wrap), (i == 28) ? 32'h1 : 32'h0);
      end
      en = 1'b0;
      tick();
      check("tog_period", 32'(period), 32'(LFSR_PERIOD));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
